lr_grant_seq: RTL and testbench
===============================

# lr_grant_seq

Sequential grant issuer that consumes a multi-bit request vector and emits it as a series of one-hot grants. Grants are issued left to right, so the MSB is served first. It sits downstream of the request-collection logic and serialises each accepted vector into single-bit grants, one per handshake, with a valid/ready interface on both sides. Internally it applies leftmost-set-bit one-hot selection to a pending register, clears each served bit, and tracks progress with a small state machine.

## Interface
- WIDTH, 4: request/grant vector width, at least 2.
- IDXW, 2: index width, equal to clog2(WIDTH).

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_vec is presented.
- in_ready  output  1  block can accept a vector.
- in_vec  input  WIDTH  request vector; bit WIDTH-1 is leftmost (highest priority).
- flush  input  1  synchronous abort of the vector in progress.
- out_valid  output  1  grant is presented.
- out_ready  input  1  downstream consumes the grant.
- out_onehot  output  WIDTH  current grant, exactly one bit set when out_valid=1.
- out_idx  output  IDXW  bit position of out_onehot.
- out_last  output  1  current grant is the final one of the vector.
- busy  output  1  a vector is in progress (state ISSUE).

## Operation
- Registers:
  - state, IDLE or ISSUE.
  - pend[WIDTH], the remaining requests.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid with nonzero in_vec: pend<=in_vec, state<=ISSUE.
  - On in_valid with in_vec==0: the vector is accepted and dropped; state stays IDLE and no grant is produced.
- ISSUE:
  - in_ready=0, out_valid=1.
  - out_onehot is the leftmost set bit of pend; out_idx is its position.
  - out_last=1 when pend has exactly one bit set.
  - On out_valid&out_ready: pend<=pend&~out_onehot. If out_last, state<=IDLE.
- Outputs are decoded from registers only. There is no combinational path from in_* or out_ready to out_*.
- When out_valid=0: out_onehot=0, out_idx=0, out_last=0.
- flush:
  - In ISSUE: state<=IDLE, pend<=0. Flush has priority over a coincident out handshake, and that grant does not count as consumed.
  - In IDLE: flush suppresses acceptance that cycle (in_ready=0).
- in_vec is ignored whenever in_ready=0.
- Reset values: state=IDLE, pend=0, out_valid=0, out_onehot=0, out_idx=0, out_last=0, busy=0.
  - in_ready=0 while rst=1 and 1 on the first cycle after rst deasserts.
  - rst mid-vector discards all remaining grants.

## Timing
- A vector accepted at edge N gives its first out_valid=1 in cycle N+1 (one-cycle latency).
- With out_ready held high, a vector with k set bits produces k grants on k consecutive cycles.
  - in_ready=1 on the cycle after the last grant.
  - Throughput is k+1 cycles per vector.
- While out_ready=0, out_onehot, out_idx and out_last hold stable.
- flush asserted at edge N: out_valid=0 and in_ready=1 in cycle N+1, unless flush is still high.
- rst dominates flush and all handshakes.

## Test plan
- Reset: hold rst high 2 cycles with in_valid=1 and in_vec=4'b1111 -> in_ready=0, out_valid=0, out_onehot=0; first cycle after release: in_ready=1 and no grant.
- Basic order: in_vec=4'b1011 accepted, out_ready=1 -> successive grants:
  - 1000 with idx 3;
  - 0010 with idx 1;
  - 0001 with idx 0 and out_last=1;
  - then in_ready=1 and out_valid=0.
- Backpressure: in_vec=4'b0110, out_ready=0 for 3 cycles -> out_onehot=0100, idx=2, out_last=0 held stable. Then out_ready=1 -> 0010 with out_last=1, next cycle IDLE.
- Zero vector: in_valid=1 with in_vec=0 -> accepted, busy stays 0, no out_valid, in_ready=1 next cycle.
- Flush: in_vec=4'b1111; after the grant 1000 completes, assert flush together with out_ready=1 on grant 0100 -> next cycle out_valid=0, in_ready=1. A new vector 4'b0001 then gives the single grant 0001 with out_last=1.
- Mid-vector reset and input isolation:
  - During ISSUE of 4'b1100, toggle in_vec/in_valid -> grants unaffected.
  - Assert rst after the first grant -> out_valid=0 next cycle and the remaining bit 0100 is never granted.

Source files
------------

// File: rtl/lr_grant_seq.sv
// lr_grant_seq: serialises an accepted request vector into one-hot grants,
// leftmost (MSB) first, one grant per out handshake.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    request vector handshake, in_vec carries requests
//   flush                aborts the vector in progress, blocks acceptance
//   out_valid/out_ready  grant handshake
//   out_onehot/out_idx   current grant and its bit position
//   out_last             current grant is the final one of the vector
//   busy                 a vector is being issued
module lr_grant_seq #(
    parameter int WIDTH = 4,
    parameter int IDXW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;

    logic [WIDTH-1:0] one_w;
    logic [IDXW-1:0]  sel_idx;
    logic [WIDTH-1:0] sel_hot;
    logic             sel_last;
    logic             accept;
    logic             consume;

    assign one_w = {{(WIDTH-1){1'b0}}, 1'b1};

    // Leftmost set bit of pend: later (higher) indices override lower ones.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pend_q[i]) begin
                sel_idx = IDXW'(i);
            end
        end
    end

    assign sel_hot = one_w << sel_idx;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign sel_last = (pend_q != '0) &&
                      ((pend_q & (pend_q - one_w)) == '0);

    // Outputs from registered state only; in_ready is the only
    // output that looks at rst and flush combinationally.
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_onehot = '0;
        out_idx    = '0;
        out_last   = 1'b0;
        busy       = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = !rst && !flush;
            end
            ISSUE: begin
                out_valid  = 1'b1;
                out_onehot = sel_hot;
                out_idx    = sel_idx;
                out_last   = sel_last;
                busy       = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready && !flush;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        unique case (state_q)
            IDLE: begin
                // A zero vector is taken and dropped without a grant.
                if (accept && (in_vec != '0)) begin
                    pend_d  = in_vec;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Flush wins over a coincident grant handshake.
                if (flush) begin
                    pend_d  = '0;
                    state_d = IDLE;
                end else if (consume) begin
                    pend_d = pend_q & ~sel_hot;
                    if (sel_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                pend_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_lr_grant_seq.sv
// tb_lr_grant_seq: directed stimulus with a grant scoreboard; a monitor
// pops expected grants on each accepted out handshake.
module tb_lr_grant_seq;

    typedef struct {
        logic [3:0] hot;
        logic [1:0] idx;
        logic       last;
    } grant_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_vec;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_onehot;
    logic [1:0] out_idx;
    logic       out_last;
    logic       busy;

    int checks = 0;
    int errors = 0;
    grant_t exp_q[$];

    always #5 clk = ~clk;

    lr_grant_seq #(.WIDTH(4), .IDXW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .busy       (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] h, input logic [1:0] i,
                        input logic l);
        grant_t g;
        g.hot  = h;
        g.idx  = i;
        g.last = l;
        exp_q.push_back(g);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every consumed grant must match the head of the queue.
    always @(negedge clk) begin
        if (out_valid && out_ready && !flush && !rst) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got %b expected none",
                         out_onehot);
            end else begin
                grant_t g;
                g = exp_q.pop_front();
                checks++;
                if (out_onehot !== g.hot || out_idx !== g.idx ||
                    out_last !== g.last) begin
                    errors++;
                    $display("FAIL grant: got %b/%0d/%b expected %b/%0d/%b",
                             out_onehot, out_idx, out_last,
                             g.hot, g.idx, g.last);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_vec    = 4'b1111;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset held two cycles with a request pending
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_in_ready", int'(in_ready), 0);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_onehot", int'(out_onehot), 0);
        end
        step();
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1);
        chk("post_rst_out_valid", int'(out_valid), 0);
        chk("post_rst_busy", int'(busy), 0);

        // Basic order 1011
        step();
        in_valid = 1'b1;
        in_vec   = 4'b1011;
        push(4'b1000, 2'd3, 1'b0);
        push(4'b0010, 2'd1, 1'b0);
        push(4'b0001, 2'd0, 1'b1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("basic_latency_valid", int'(out_valid), 1);
        chk("basic_busy", int'(busy), 1);
        chk("basic_in_ready_low", int'(in_ready), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("basic_done_in_ready", int'(in_ready), 1);
        chk("basic_done_valid", int'(out_valid), 0);

        // Backpressure 0110
        step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_vec    = 4'b0110;
        push(4'b0100, 2'd2, 1'b0);
        push(4'b0010, 2'd1, 1'b1);
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_onehot", int'(out_onehot), 4);
            chk("bp_idx", int'(out_idx), 2);
            chk("bp_last", int'(out_last), 0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_first_onehot", int'(out_onehot), 4);
        step();
        @(negedge clk);
        chk("bp_second_last", int'(out_last), 1);
        step();
        @(negedge clk);
        chk("bp_idle_valid", int'(out_valid), 0);
        chk("bp_idle_in_ready", int'(in_ready), 1);

        // Zero vector accepted and dropped
        step();
        in_valid = 1'b1;
        in_vec   = 4'b0000;
        @(negedge clk);
        chk("zero_in_ready", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("zero_busy", int'(busy), 0);
        chk("zero_valid", int'(out_valid), 0);
        chk("zero_in_ready_next", int'(in_ready), 1);

        // Flush in IDLE blocks acceptance
        step();
        in_valid = 1'b1;
        in_vec   = 4'b0101;
        flush    = 1'b1;
        @(negedge clk);
        chk("idle_flush_in_ready", int'(in_ready), 0);
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        chk("idle_flush_busy", int'(busy), 0);

        // Flush during grant 0100 of 1111
        step();
        in_valid = 1'b1;
        in_vec   = 4'b1111;
        push(4'b1000, 2'd3, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_onehot", int'(out_onehot), 4);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", int'(out_valid), 0);
        chk("flush_in_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_vec   = 4'b0001;
        push(4'b0001, 2'd0, 1'b1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("single_last", int'(out_last), 1);
        step();
        @(negedge clk);
        chk("single_done_valid", int'(out_valid), 0);

        // Input isolation then mid-vector reset on 1100
        step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_vec    = 4'b1100;
        push(4'b1000, 2'd3, 1'b0);
        step();
        for (int c = 0; c < 2; c++) begin
            in_vec   = (c == 0) ? 4'b0011 : 4'b0111;
            in_valid = (c == 0);
            @(negedge clk);
            chk("iso_onehot", int'(out_onehot), 8);
            chk("iso_idx", int'(out_idx), 3);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_in_ready_after", int'(in_ready), 1);
        for (int c = 0; c < 4; c++) begin
            step();
            @(negedge clk);
            chk("mid_rst_no_grant", int'(out_valid), 0);
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
